// File: rtl/mux_scan_pkg.sv
// Shared types and default sizing for the mux scan sequencer.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int N_CH_DEF  = 32;
    localparam int SEL_W_DEF = 5;

endpackage

// File: rtl/mux_scan_sequencer.sv
// Walks a 32:1 mux select through every channel and assembles the samples into one word.
// Optional MUX_SCAN_SETTLE_EN: two cycles per channel (drive, then sample) for slow mux outputs.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             stop,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_y,
    output logic [N_CH-1:0]  word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    state_t           r_state;
    logic [SEL_W-1:0] r_ch;
    logic [N_CH-1:0]  r_word;
    logic             r_valid;
    logic             r_cont;
    logic             w_sample;

`ifdef MUX_SCAN_SETTLE_EN
    // r_phase=0 is the settle cycle for the current select, r_phase=1 samples it.
    logic r_phase;
    assign w_sample = r_phase;
`else
    assign w_sample = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_cont  <= 1'b0;
`ifdef MUX_SCAN_SETTLE_EN
            r_phase <= 1'b0;
`endif
        end else if (stop) begin
            // Partial word is left in place but never flagged valid.
            r_state <= IDLE;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_cont  <= 1'b0;
`ifdef MUX_SCAN_SETTLE_EN
            r_phase <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_ch <= '0;
                    if (start) begin
                        r_cont  <= continuous;
                        r_state <= SCAN;
                        r_word  <= '0;
`ifdef MUX_SCAN_SETTLE_EN
                        r_phase <= 1'b0;
`endif
                    end
                end
                SCAN: begin
`ifdef MUX_SCAN_SETTLE_EN
                    r_phase <= ~r_phase;
`endif
                    if (w_sample) begin
                        r_word[r_ch] <= mux_y;
                        if (r_ch == LAST_CH) begin
                            r_state <= HOLD;
                            r_valid <= 1'b1;
                        end else begin
                            r_ch <= r_ch + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (word_ready) begin
                        r_valid <= 1'b0;
                        r_ch    <= '0;
                        if (r_cont) begin
                            r_state <= SCAN;
                            r_word  <= '0;
`ifdef MUX_SCAN_SETTLE_EN
                            r_phase <= 1'b0;
`endif
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ch    <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mux_sel    = r_ch;
    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign busy       = (r_state == SCAN) || (r_state == HOLD);

endmodule
